// File: rtl/pll_lock_reset_seq_if.sv
// Bus between the PLL lock/reset sequencer and its surroundings.
// master drives pll_lock and clear_lost; slave (the sequencer) drives the rest.
interface pll_lock_reset_seq_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_lock;
    logic             clear_lost;
    logic             core_rst_n;
    logic [1:0]       state;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output pll_lock,
        output clear_lost,
        input  core_rst_n,
        input  state,
        input  lock_lost,
        input  loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  clear_lost,
        output core_rst_n,
        output state,
        output lock_lost,
        output loss_cnt
    );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// Lock-qualified reset sequencer: sync PLL lock, require a stable window, hold, then release core reset.
// Optional lock-loss debug counter enabled by defining PLL_LOCK_RESET_SEQ_LOSS_CNT_EN.
module pll_lock_reset_seq #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_reset_seq_if.slave  bus
);
    localparam int unsigned CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   core_rst_n_q;

    // Metastability chain; the only place the raw lock is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Sequencer; one counter serves both the stable window and the hold phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q      <= RUN;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q      <= WAIT_LOCK;
                        core_rst_n_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= WAIT_LOCK;
                    core_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.state      = 2'(state_q);

`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
    logic             loss_event_c;
    logic             lock_lost_q;
    logic [CNT_W-1:0] loss_cnt_q;

    assign loss_event_c = (state_q == RUN) && !lock_s;

    // Sticky flag and saturating count; a loss in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else if (loss_event_c) begin
            lock_lost_q <= 1'b1;
            if (bus.clear_lost) begin
                loss_cnt_q <= CNT_W'(1);
            end else if (!(&loss_cnt_q)) begin
                loss_cnt_q <= loss_cnt_q + CNT_W'(1);
            end
        end else if (bus.clear_lost) begin
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end
    end

    assign bus.lock_lost = lock_lost_q;
    assign bus.loss_cnt  = loss_cnt_q;
`else
    logic unused_clear_lost;

    assign unused_clear_lost = bus.clear_lost;
    assign bus.lock_lost     = 1'b0;
    assign bus.loss_cnt      = '0;
`endif

endmodule
